// File: rtl/simple_fifo_pkg.sv
// -----------------------------------------------------------------------------
// simple_fifo_pkg
// Shared constants, controller state type and the request decoder for the
// simple_fifo block.
//
// Contents:
//   DATA_WIDTH, DEPTH, ADDR_WIDTH, COUNT_WIDTH  - fixed geometry
//   state_t                                     - controller operation/state
//   decode_op()                                 - maps a request to an operation
// -----------------------------------------------------------------------------
package simple_fifo_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int DEPTH       = 16;
  localparam int ADDR_WIDTH  = 4;
  // One extra bit so the count can represent both 0 and DEPTH.
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

  // The controller state names the operation performed on the most recent
  // edge; INIT only exists between reset and the first edge.
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } state_t;

  // Decode one request. Simultaneous read and write is deliberately ignored
  // rather than serviced, so the FIFO never needs a read/write bypass path.
  function automatic state_t decode_op(
    input logic wr_req,
    input logic rd_req,
    input logic is_full,
    input logic is_empty
  );
    state_t op;
    op = NO_OP;
    unique case ({wr_req, rd_req})
      2'b10:   op = is_full  ? WR_ERROR : WRITE;
      2'b01:   op = is_empty ? RD_ERROR : READ;
      default: op = NO_OP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/simple_fifo_mem.sv
// -----------------------------------------------------------------------------
// simple_fifo_mem
// DEPTH x DATA_WIDTH storage for simple_fifo: one synchronous write port and
// one registered read port. The array itself is never reset so it maps onto
// block or distributed RAM; only the read-data register is reset.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data loads mem[rd_addr] when high
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds when rd_en is low
// -----------------------------------------------------------------------------
module simple_fifo_mem
  import simple_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Storage array: no reset, so contents survive reset and stay RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register. The controller never reads and writes on the same edge,
  // so read-during-write behaviour of the array does not matter here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/simple_fifo.sv
// -----------------------------------------------------------------------------
// simple_fifo
// Single-clock 16 x 32 FIFO with registered read data, occupancy count and
// per-edge handshake status. Each rising edge performs at most one operation
// (write, read, rejected write, rejected read or nothing).
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset; discards all contents
//   rd_en       in   read request
//   wr_en       in   write request (ignored together with rd_en)
//   d_in        in   write data
//   d_out       out  read data, updated only by a successful read
//   full        out  data_count == DEPTH
//   empty       out  data_count == 0
//   wr_ack      out  previous edge performed a write
//   wr_err      out  previous edge rejected a write because FIFO was full
//   rd_ack      out  previous edge performed a read
//   rd_err      out  previous edge rejected a read because FIFO was empty
//   data_count  out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module simple_fifo
  import simple_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  d_in,
  output logic [DATA_WIDTH-1:0]  d_out,
  output logic                   full,
  output logic                   empty,
  output logic                   wr_ack,
  output logic                   wr_err,
  output logic                   rd_ack,
  output logic                   rd_err,
  output logic [COUNT_WIDTH-1:0] data_count
);

  state_t                 state_reg;
  state_t                 op_next;
  logic [ADDR_WIDTH-1:0]  wr_ptr_reg;
  logic [ADDR_WIDTH-1:0]  rd_ptr_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   wr_ack_reg;
  logic                   wr_err_reg;
  logic                   rd_ack_reg;
  logic                   rd_err_reg;
  logic                   mem_wr;
  logic                   mem_rd;

  // Flags come from the registered count, so they describe the FIFO as it
  // stands after the last edge and are stable for the whole cycle.
  assign full  = (count_reg == COUNT_WIDTH'(DEPTH));
  assign empty = (count_reg == '0);

  // Operation the coming edge will perform.
  assign op_next = decode_op(wr_en, rd_en, full, empty);
  assign mem_wr  = (op_next == WRITE);
  assign mem_rd  = (op_next == READ);

  // Controller: state, pointers, occupancy and status flags all update
  // together on the edge that samples the request. Pointers are exactly
  // ADDR_WIDTH bits wide so the 15 -> 0 wrap falls out of the addition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= INIT;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      wr_ack_reg <= 1'b0;
      wr_err_reg <= 1'b0;
      rd_ack_reg <= 1'b0;
      rd_err_reg <= 1'b0;
    end else begin
      state_reg  <= op_next;
      wr_ack_reg <= (op_next == WRITE);
      wr_err_reg <= (op_next == WR_ERROR);
      rd_ack_reg <= (op_next == READ);
      rd_err_reg <= (op_next == RD_ERROR);
      case (op_next)
        WRITE: begin
          wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
          count_reg  <= count_reg + COUNT_WIDTH'(1);
        end
        READ: begin
          rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
          count_reg  <= count_reg - COUNT_WIDTH'(1);
        end
        default: begin
          // NO_OP and both error cases leave pointers and count alone.
        end
      endcase
    end
  end

  simple_fifo_mem u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (mem_wr),
    .wr_addr (wr_ptr_reg),
    .wr_data (d_in),
    .rd_en   (mem_rd),
    .rd_addr (rd_ptr_reg),
    .rd_data (d_out)
  );

  assign wr_ack     = wr_ack_reg;
  assign wr_err     = wr_err_reg;
  assign rd_ack     = rd_ack_reg;
  assign rd_err     = rd_err_reg;
  assign data_count = count_reg;

  // The status flags are one-hot-or-zero by construction; the state register
  // must agree with them (INIT and NO_OP both mean "no flag").
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert ($onehot0({wr_ack_reg, wr_err_reg, rd_ack_reg, rd_err_reg}))
        else $error("simple_fifo: more than one status flag set");
      assert ((state_reg == WRITE) == wr_ack_reg)
        else $error("simple_fifo: state/wr_ack disagree");
    end
  end

endmodule

// File: tb/tb_simple_fifo.sv
// -----------------------------------------------------------------------------
// tb_simple_fifo
// Scoreboard bench for simple_fifo. The stimulus process drives a request each
// cycle, runs it through a queue-based reference model and pushes the expected
// post-edge outputs; a separate monitor pops one entry after every rising edge
// and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_simple_fifo;

  logic        clk;
  logic        reset_n;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;
  logic [4:0]  data_count;

  simple_fifo dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .d_in       (d_in),
    .d_out      (d_out),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  flags;   // {wr_ack, wr_err, rd_ack, rd_err}
    logic [31:0] dout;
    int          cnt;
    string       what;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_q[$];
  logic [31:0] model_dout;
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue; its size is the occupancy.
  task automatic do_op(input logic w, input logic r, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    d_in  = d;
    e.flags = 4'b0000;
    if (w && !r) begin
      if (model_q.size() < 16) begin
        model_q.push_back(d);
        e.flags = 4'b1000;
        e.what  = $sformatf("write 0x%08h", d);
      end else begin
        e.flags = 4'b0100;
        e.what  = $sformatf("write 0x%08h (full)", d);
      end
    end else if (r && !w) begin
      if (model_q.size() > 0) begin
        model_dout = model_q.pop_front();
        e.flags = 4'b0010;
        e.what  = $sformatf("read 0x%08h", model_dout);
      end else begin
        e.flags = 4'b0001;
        e.what  = "read (empty)";
      end
    end else begin
      e.what = (w && r) ? "nop (both)" : "nop";
    end
    e.dout = model_dout;
    e.cnt  = model_q.size();
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per stimulated edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.what, " flags"}, {28'd0, wr_ack, wr_err, rd_ack, rd_err}, {28'd0, e.flags});
        check({e.what, " d_out"}, d_out, e.dout);
        check({e.what, " count"}, {27'd0, data_count}, e.cnt);
        check({e.what, " full"},  {31'd0, full},  {31'd0, e.cnt == 16});
        check({e.what, " empty"}, {31'd0, empty}, {31'd0, e.cnt == 0});
        $display("txn %-28s flags=%b d_out=%08h count=%0d",
                 e.what, {wr_ack, wr_err, rd_ack, rd_err}, d_out, data_count);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, " d_out"}, d_out, 32'd0);
    check({tag, " count"}, {27'd0, data_count}, 32'd0);
    check({tag, " empty"}, {31'd0, empty}, 32'd1);
    check({tag, " full"},  {31'd0, full},  32'd0);
    check({tag, " flags"}, {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
  endtask

  logic [31:0] fill_data [16];
  logic [31:0] known [6];
  logic [31:0] refill [5];

  initial begin
    total      = 0;
    bad        = 0;
    model_dout = 32'd0;
    reset_n    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    d_in       = 32'd0;

    known  = '{32'h6b3c3ad9, 32'hf414ecaa, 32'hd55a0c94, 32'h1c9ffec6,
               32'h20afb913, 32'h1a6bd0b2};
    refill = '{32'h80aef943, 32'h80aef943, 32'h87bd2c7b, 32'ha9385939,
               32'he8e56cf4};
    for (int i = 0; i < 16; i++) begin
      fill_data[i] = (i < 6) ? known[i] : $urandom;
    end
    fill_data[15] = 32'hc3ed57cf;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to 16, then two overflowing writes.
    for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, fill_data[i]);
    do_op(1'b1, 1'b0, 32'h17213d35);
    do_op(1'b1, 1'b0, 32'h8c776fa6);

    // Idle and the ignored simultaneous request.
    do_op(1'b0, 1'b0, 32'h0);
    do_op(1'b1, 1'b1, 32'hdeadbeef);

    // Six reads, then five writes that wrap the write pointer.
    for (int i = 0; i < 6; i++) do_op(1'b0, 1'b1, $urandom);
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, refill[i]);

    // Drain with rd_en held, running past empty into underflow.
    for (int i = 0; i < 35; i++) do_op(1'b0, 1'b1, $urandom);

    // Random traffic with phases biased towards writing or reading so that
    // both the full and empty boundaries are visited repeatedly.
    for (int ph = 0; ph < 12; ph++) begin
      int wr_bias;
      wr_bias = (ph % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 120; i++) begin
        int roll;
        logic w;
        logic r;
        roll = $urandom_range(0, 99);
        w    = (roll < wr_bias);
        r    = ($urandom_range(0, 99) < (100 - wr_bias));
        do_op(w, r, $urandom);
      end
    end

    // Make sure there is something stored, then reset between edges.
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, $urandom);
    do_op(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_state("async reset");
    model_q.delete();
    model_dout = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;

    // After reset the FIFO must start from empty again.
    do_op(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) do_op(1'b0, 1'b1, 32'h0);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
